// File: rtl/ftdi_245fifo_chip_model_if.sv
// Bundle between the FT232H chip model and whoever drives it (host side + FPGA side).
// slave: the chip model. master: host/controller stimulus (testbench or controller).
interface ftdi_245fifo_chip_model_if #(
    parameter int RX_EA = 4,
    parameter int TX_EA = 4
);
    logic             host_in_valid;
    logic             host_in_ready;
    logic [7:0]       host_in_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [7:0]       host_out_data;
    logic             ftdi_rxf_n;
    logic             ftdi_txe_n;
    logic             ftdi_oe_n;
    logic             ftdi_rd_n;
    logic             ftdi_wr_n;
    logic [7:0]       ftdi_data_i;
    logic [7:0]       ftdi_data_o;
    logic             ftdi_data_t;
    logic             protocol_err;
    logic [RX_EA:0]   rx_level;
    logic [TX_EA:0]   tx_level;

    modport slave (
        input  host_in_valid, host_in_data, host_out_ready,
        input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i,
        output host_in_ready, host_out_valid, host_out_data,
        output ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_data_t,
        output protocol_err, rx_level, tx_level
    );

    modport master (
        output host_in_valid, host_in_data, host_out_ready,
        output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i,
        input  host_in_ready, host_out_valid, host_out_data,
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_data_t,
        input  protocol_err, rx_level, tx_level
    );
endinterface

// File: rtl/ftdi_245fifo_chip_model.sv
// FT232H 245 sync-FIFO responder: host->FPGA RX FIFO on RXF#/data, FPGA->host TX FIFO via WR#.
// Ports: clk, rst_async (async active-high), bus (slave modport: host_in/host_out streams,
//   RXF#/TXE#/OE#/RD#/WR#, data in/out/drive-enable, protocol_err, rx_level, tx_level).
// Optional macro FTDI_THROTTLE_EN: periodically forces TXE# high to emulate USB backpressure.
module ftdi_245fifo_chip_model #(
    parameter int RX_EA           = 4,
    parameter int TX_EA           = 4,
    parameter int THROTTLE_PERIOD = 64,
    parameter int THROTTLE_LEN    = 8
) (
    input  logic                       clk,
    input  logic                       rst_async,
    ftdi_245fifo_chip_model_if.slave   bus
);
    localparam int RX_DEPTH = 1 << RX_EA;
    localparam int TX_DEPTH = 1 << TX_EA;
    localparam logic [RX_EA:0] RX_FULL = (RX_EA + 1)'(RX_DEPTH);
    localparam logic [TX_EA:0] TX_FULL = (TX_EA + 1)'(TX_DEPTH);

    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [RX_EA-1:0] rx_wptr_q, rx_rptr_q;
    logic [TX_EA-1:0] tx_wptr_q, tx_rptr_q;
    logic [RX_EA:0]   rx_level_q, rx_level_d;
    logic [TX_EA:0]   tx_level_q, tx_level_d;
    logic             rxf_n_q, txe_n_q, data_t_q, err_q, err_d;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic             throttle_next;

    // Full check uses current level only: a same-edge pop never frees room.
    assign rx_push = bus.host_in_valid & (rx_level_q != RX_FULL);
    // rxf_n_q low implies non-empty, so no separate empty guard needed.
    assign rx_pop  = ~bus.ftdi_rd_n & ~bus.ftdi_oe_n & ~rxf_n_q;
    // txe_n_q low implies not full; writes while TXE# high are dropped.
    assign tx_push = ~bus.ftdi_wr_n & ~txe_n_q;
    assign tx_pop  = bus.host_out_ready & (tx_level_q != '0);

    always_comb begin
        rx_level_d = rx_level_q;
        tx_level_d = tx_level_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + (RX_EA + 1)'(1);
            2'b01:   rx_level_d = rx_level_q - (RX_EA + 1)'(1);
            default: rx_level_d = rx_level_q;
        endcase
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + (TX_EA + 1)'(1);
            2'b01:   tx_level_d = tx_level_q - (TX_EA + 1)'(1);
            default: tx_level_d = tx_level_q;
        endcase
        err_d = err_q
              | (~bus.ftdi_rd_n & bus.ftdi_oe_n)
              | (~bus.ftdi_wr_n & ~bus.ftdi_oe_n);
    end

`ifdef FTDI_THROTTLE_EN
    localparam int TW = $clog2(THROTTLE_PERIOD);
    logic [TW-1:0] thr_q, thr_d;

    assign thr_d = (thr_q == TW'(THROTTLE_PERIOD - 1)) ? '0 : thr_q + TW'(1);
    assign throttle_next = (thr_d < TW'(THROTTLE_LEN));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) thr_q <= '0;
        else           thr_q <= thr_d;
    end
`else
    logic unused_thr;
    assign unused_thr    = ^{THROTTLE_PERIOD, THROTTLE_LEN};
    assign throttle_next = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_level_q <= '0;
            tx_level_q <= '0;
            rxf_n_q    <= 1'b1;
            txe_n_q    <= 1'b1;
            data_t_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + RX_EA'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_EA'(1);
            if (tx_push) tx_wptr_q <= tx_wptr_q + TX_EA'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_EA'(1);
            rx_level_q <= rx_level_d;
            tx_level_q <= tx_level_d;
            rxf_n_q    <= (rx_level_d == '0);
            txe_n_q    <= (tx_level_d == TX_FULL) | throttle_next;
            data_t_q   <= ~bus.ftdi_oe_n;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= bus.host_in_data;
        if (tx_push) tx_mem_q[tx_wptr_q] <= bus.ftdi_data_i;
    end

    assign bus.host_in_ready  = (rx_level_q != RX_FULL);
    assign bus.host_out_valid = (tx_level_q != '0);
    assign bus.host_out_data  = tx_mem_q[tx_rptr_q];
    assign bus.ftdi_rxf_n     = rxf_n_q;
    assign bus.ftdi_txe_n     = txe_n_q;
    assign bus.ftdi_data_o    = rx_mem_q[rx_rptr_q];
    assign bus.ftdi_data_t    = data_t_q;
    assign bus.protocol_err   = err_q;
    assign bus.rx_level       = rx_level_q;
    assign bus.tx_level       = tx_level_q;
endmodule

// File: tb/tb_ftdi_245fifo_chip_model.sv
// Self-checking bench for ftdi_245fifo_chip_model: vector table for the RX path,
// hand sequences for FIFO-full, TX fill/drain, protocol error, async reset, throttle.
module tb_ftdi_245fifo_chip_model;
    localparam int RX_EA = 4;
    localparam int TX_EA = 4;
`ifdef FTDI_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftdi_245fifo_chip_model_if #(.RX_EA(RX_EA), .TX_EA(TX_EA)) bus ();

    ftdi_245fifo_chip_model #(
        .RX_EA(RX_EA), .TX_EA(TX_EA),
        .THROTTLE_PERIOD(64), .THROTTLE_LEN(8)
    ) dut (
        .clk(clk),
        .rst_async(rst),
        .bus(bus)
    );

    typedef struct {
        logic       hv;
        logic [7:0] hd;
        logic       oe_n;
        logic       rd_n;
        logic       pop;
        logic [4:0] e_lvl;
        logic       e_rxf;
        logic       e_dt;
    } vec_t;

    vec_t       v [14];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_sb [$];
    logic [7:0] tx_sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.host_in_valid  = 1'b0;
        bus.host_in_data   = 8'h00;
        bus.host_out_ready = 1'b0;
        bus.ftdi_oe_n      = 1'b1;
        bus.ftdi_rd_n      = 1'b1;
        bus.ftdi_wr_n      = 1'b1;
        bus.ftdi_data_i    = 8'h00;
    endtask

    // Compare the byte the controller samples at the coming edge.
    task automatic rx_pop_chk(input string name);
        checks++;
        if (rx_sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, bus.ftdi_data_o);
        end else begin
            logic [7:0] e;
            e = rx_sb.pop_front();
            if (bus.ftdi_data_o !== e) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, bus.ftdi_data_o, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int k;
        v[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0};
        v[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0};
        v[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
        v[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1};
        v[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1};
        v[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
        v[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1};
        v[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1};
        v[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
        v[9]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0};
        v[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1};
        v[11] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
        v[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1};
        v[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};

        idle();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);
        chk("rst_txe_n", 32'(bus.ftdi_txe_n), 32'd1);
        chk("rst_data_t", 32'(bus.ftdi_data_t), 32'd0);
        chk("rst_err", 32'(bus.protocol_err), 32'd0);
        chk("rst_rx_level", 32'(bus.rx_level), 32'd0);
        chk("rst_tx_level", 32'(bus.tx_level), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_txe_n", 32'(bus.ftdi_txe_n), 32'd1);
        step();
        chk("edge1_txe_n", 32'(bus.ftdi_txe_n), 32'(THR));
        chk("edge1_rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);

        for (int i = 0; i < 14; i++) begin
            bus.host_in_valid = v[i].hv;
            bus.host_in_data  = v[i].hd;
            bus.ftdi_oe_n     = v[i].oe_n;
            bus.ftdi_rd_n     = v[i].rd_n;
            if (v[i].hv) rx_sb.push_back(v[i].hd);
            if (v[i].pop) rx_pop_chk($sformatf("vec%0d_data", i));
            step();
            chk($sformatf("vec%0d_rx_level", i), 32'(bus.rx_level), 32'(v[i].e_lvl));
            chk($sformatf("vec%0d_rxf_n", i), 32'(bus.ftdi_rxf_n), 32'(v[i].e_rxf));
            chk($sformatf("vec%0d_data_t", i), 32'(bus.ftdi_data_t), 32'(v[i].e_dt));
            chk($sformatf("vec%0d_err", i), 32'(bus.protocol_err), 32'd0);
        end
        idle();

        for (int i = 0; i < 16; i++) begin
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = 8'(8'h80 + i);
            rx_sb.push_back(8'(8'h80 + i));
            step();
        end
        chk("full_rx_level", 32'(bus.rx_level), 32'd16);
        chk("full_in_ready", 32'(bus.host_in_ready), 32'd0);
        bus.host_in_data = 8'hEE;
        step();
        chk("full_refuse_level", 32'(bus.rx_level), 32'd16);
        bus.ftdi_oe_n = 1'b0;
        step();
        bus.ftdi_rd_n = 1'b0;
        rx_pop_chk("full_pop_data");
        step();
        chk("full_poppush_level", 32'(bus.rx_level), 32'd15);
        chk("full_poppush_ready", 32'(bus.host_in_ready), 32'd1);
        bus.host_in_valid = 1'b0;
        k = 0;
        while (rx_sb.size() > 0 && k < 20) begin
            if (bus.ftdi_rxf_n !== 1'b0) begin
                chk("drain_rxf_n", 32'(bus.ftdi_rxf_n), 32'd0);
                break;
            end
            rx_pop_chk("drain_data");
            step();
            k++;
        end
        chk("drain_sb_left", 32'(rx_sb.size()), 32'd0);
        chk("drain_rx_level", 32'(bus.rx_level), 32'd0);
        chk("drain_rxf_n_end", 32'(bus.ftdi_rxf_n), 32'd1);
        idle();
        step();

`ifndef FTDI_THROTTLE_EN
        for (int i = 0; i < 17; i++) begin
            bus.ftdi_wr_n   = 1'b0;
            bus.ftdi_data_i = 8'(i);
            if (i < 16) tx_sb.push_back(8'(i));
            step();
            chk($sformatf("txfill%0d_level", i), 32'(bus.tx_level),
                (i < 16) ? 32'(i + 1) : 32'd16);
            chk($sformatf("txfill%0d_txe_n", i), 32'(bus.ftdi_txe_n),
                (i >= 15) ? 32'd1 : 32'd0);
        end
        bus.ftdi_wr_n      = 1'b1;
        bus.host_out_ready = 1'b1;
        k = 0;
        while (tx_sb.size() > 0 && k < 40) begin
            if (bus.host_out_valid !== 1'b1) begin
                chk("txdrain_valid", 32'(bus.host_out_valid), 32'd1);
                break;
            end
            chk("txdrain_data", 32'(bus.host_out_data), 32'(tx_sb.pop_front()));
            step();
            k++;
        end
        bus.host_out_ready = 1'b0;
        chk("txdrain_sb_left", 32'(tx_sb.size()), 32'd0);
        chk("txdrain_level", 32'(bus.tx_level), 32'd0);
        chk("txdrain_valid_end", 32'(bus.host_out_valid), 32'd0);
        chk("txdrain_txe_n", 32'(bus.ftdi_txe_n), 32'd0);
`endif

        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 8'h42;
        step();
        idle();
        bus.ftdi_rd_n = 1'b0;
        step();
        bus.ftdi_rd_n = 1'b1;
        chk("err_rd_oe_hi", 32'(bus.protocol_err), 32'd1);
        chk("err_no_pop", 32'(bus.rx_level), 32'd1);
        repeat (3) step();
        chk("err_sticky", 32'(bus.protocol_err), 32'd1);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_err", 32'(bus.protocol_err), 32'd0);
        chk("async_rst_rx_level", 32'(bus.rx_level), 32'd0);
        chk("async_rst_rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);
        chk("async_rst_txe_n", 32'(bus.ftdi_txe_n), 32'd1);
        repeat (2) step();
        rst = 1'b0;
        step();
        bus.ftdi_oe_n   = 1'b0;
        bus.ftdi_wr_n   = 1'b0;
        bus.ftdi_data_i = 8'h99;
        step();
        idle();
        chk("err_wr_oe_lo", 32'(bus.protocol_err), 32'd1);

`ifdef FTDI_THROTTLE_EN
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (bus.ftdi_txe_n) cnt++;
        end
        chk("thr_high_count", 32'(cnt), 32'd16);
        k = 0;
        while (bus.ftdi_txe_n !== 1'b1 && k < 70) begin
            step();
            k++;
        end
        chk("thr_wait_txe_n", 32'(bus.ftdi_txe_n), 32'd1);
        bus.ftdi_wr_n   = 1'b0;
        bus.ftdi_data_i = 8'h77;
        step();
        idle();
        chk("thr_wr_ignored", 32'(bus.tx_level), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
